// File: rtl/rr_adder_arbiter.sv
// ---------------------------------------------------------------------------
// rr_adder_arbiter
//
// Shares one fixed-point adder among N requesters. While idle it picks a
// winner with a rotating priority: requests strictly below the last granted
// index go first, with the highest such index winning. If there are none, the
// search wraps around to the highest requesting index overall, so service
// rotates downward (7,6,...,0,7,...). The grant is registered together with a
// one-cycle start pulse. It is held until the adder reports done, or until
// the watchdog forces a release.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req        [N-1:0]    request vector, bit i = requester i wants the adder
//   done       adder completion pulse; accepted from the cycle after start
//   gnt        [N-1:0]    one-hot grant, all zero when idle
//   gnt_idx    [IDXW-1:0] binary index of the granted requester, 0 when idle
//   gnt_valid  a grant is active (same as |gnt)
//   start      one-cycle pulse in the first grant cycle
//   timeout    one-cycle pulse when the watchdog forces a release
//
// All outputs come straight from flops. None of them depends
// combinationally on req or done.
// ---------------------------------------------------------------------------
module rr_adder_arbiter #(
   parameter int N       = 8,
   parameter int IDXW    = $clog2(N),
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic            done,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            gnt_valid,
   output logic            start,
   output logic            timeout
);

   // Watchdog counter width and its terminal (saturation) value.
   localparam int             WDW    = $clog2(TIMEOUT);
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [N-1:0]    gnt_r;
   logic [N-1:0]    gnt_nxt_s;
   logic [IDXW-1:0] gnt_idx_r;
   logic [IDXW-1:0] gnt_idx_nxt_s;
   logic            gnt_valid_r;
   logic            gnt_valid_nxt_s;
   logic            start_r;
   logic            start_nxt_s;
   logic            timeout_r;
   logic            timeout_nxt_s;
   logic [IDXW-1:0] ptr_r;
   logic [IDXW-1:0] ptr_nxt_s;
   logic [WDW-1:0]  wd_r;
   logic [WDW-1:0]  wd_nxt_s;

   logic [N-1:0]    masked_s;
   logic [IDXW-1:0] win_idx_s;
   logic            done_ok_s;
   logic            expire_s;
   logic            release_s;

   // Bits strictly below position p set, all others clear.
   function automatic logic [N-1:0] below_mask(input logic [IDXW-1:0] p);
      logic [N-1:0] m;
      m = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (i < int'(p)) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   // Index of the highest set bit; 0 when v is empty (callers guard that case).
   function automatic logic [IDXW-1:0] top_index(input logic [N-1:0] v);
      logic [IDXW-1:0] idx;
      idx = {IDXW{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            idx = IDXW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // One-hot decode of a binary index.
   function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
      logic [N-1:0] v;
      v = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (IDXW'(i) == idx) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

   // Rotating winner search: requests below ptr first, otherwise wrap to the top.
   always_comb begin
      masked_s = req & below_mask(ptr_r);
      if (masked_s != {N{1'b0}}) begin
         win_idx_s = top_index(masked_s);
      end else begin
         win_idx_s = top_index(req);
      end
   end

   // Release qualifiers. A done pulse arriving in the start cycle is dropped,
   // and a real done wins over a simultaneous watchdog expiry.
   always_comb begin
      done_ok_s = done & ~start_r;
      expire_s  = (wd_r == WD_MAX);
      release_s = done_ok_s | expire_s;
   end

   // Next-state and next-output logic for the IDLE/GRANT controller.
   always_comb begin
      state_nxt_s   = state_r;
      gnt_nxt_s     = gnt_r;
      gnt_idx_nxt_s = gnt_idx_r;
      start_nxt_s   = 1'b0;
      timeout_nxt_s = 1'b0;
      ptr_nxt_s     = ptr_r;
      wd_nxt_s      = wd_r;

      case (state_r)
         IDLE: begin
            if (req != {N{1'b0}}) begin
               state_nxt_s   = GRANT;
               gnt_nxt_s     = onehot(win_idx_s);
               gnt_idx_nxt_s = win_idx_s;
               start_nxt_s   = 1'b1;
               wd_nxt_s      = {WDW{1'b0}};
            end else begin
               state_nxt_s   = IDLE;
            end
         end

         GRANT: begin
            if (release_s) begin
               // The pointer remembers who just finished, so the next search
               // starts below it.
               state_nxt_s   = IDLE;
               gnt_nxt_s     = {N{1'b0}};
               gnt_idx_nxt_s = {IDXW{1'b0}};
               ptr_nxt_s     = gnt_idx_r;
               wd_nxt_s      = {WDW{1'b0}};
               timeout_nxt_s = expire_s & ~done_ok_s;
            end else if (wd_r != WD_MAX) begin
               wd_nxt_s      = wd_r + WDW'(1);
            end else begin
               wd_nxt_s      = wd_r;
            end
         end

         default: begin
            state_nxt_s   = IDLE;
            gnt_nxt_s     = {N{1'b0}};
            gnt_idx_nxt_s = {IDXW{1'b0}};
            ptr_nxt_s     = {IDXW{1'b0}};
            wd_nxt_s      = {WDW{1'b0}};
         end
      endcase

      gnt_valid_nxt_s = (gnt_nxt_s != {N{1'b0}});
   end

   // State and output registers; reset abandons any grant without a timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         gnt_r       <= {N{1'b0}};
         gnt_idx_r   <= {IDXW{1'b0}};
         gnt_valid_r <= 1'b0;
         start_r     <= 1'b0;
         timeout_r   <= 1'b0;
         ptr_r       <= {IDXW{1'b0}};
         wd_r        <= {WDW{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         gnt_r       <= gnt_nxt_s;
         gnt_idx_r   <= gnt_idx_nxt_s;
         gnt_valid_r <= gnt_valid_nxt_s;
         start_r     <= start_nxt_s;
         timeout_r   <= timeout_nxt_s;
         ptr_r       <= ptr_nxt_s;
         wd_r        <= wd_nxt_s;
      end
   end

   assign gnt       = gnt_r;
   assign gnt_idx   = gnt_idx_r;
   assign gnt_valid = gnt_valid_r;
   assign start     = start_r;
   assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_adder_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for rr_adder_arbiter (N=8, TIMEOUT=64).
// A transaction-level reference model runs in the driver. It picks winners by
// scanning downward from the last granted index, and it tracks the age of the
// current grant. Each completed transaction (index, length, timeout flag) is
// queued when the model releases it. A separate negedge monitor rebuilds
// transactions from the DUT outputs and compares them against the queue.
// ---------------------------------------------------------------------------
module tb_rr_adder_arbiter;
   localparam int N       = 8;
   localparam int IDXW    = 3;
   localparam int TIMEOUT = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic            done;
   logic [N-1:0]    gnt;
   logic [IDXW-1:0] gnt_idx;
   logic            gnt_valid;
   logic            start;
   logic            timeout;

   always #5 clk = ~clk;

   rr_adder_arbiter #(.N(N), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
      .start(start), .timeout(timeout)
   );

   typedef struct {
      int idx;
      int len;
      bit tmo;
   } txn_t;

   txn_t exp_q[$];
   int   obs_idx[$];
   int   obs_gap[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // reference model state
   bit m_busy = 1'b0;
   int m_idx  = 0;
   int m_ptr  = 0;
   int m_age  = 0;
   int cur_delay = 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Rotating priority: first requester found scanning down from ptr-1, wrapping.
   function automatic int rr_pick(input logic [7:0] r, input int p);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (p - k + N) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   // Model reaction to one clock edge with the inputs that were applied to it.
   task automatic model_edge(input logic [7:0] r, input logic d);
      txn_t t;
      if (!m_busy) begin
         if (r != 8'h00) begin
            m_idx  = rr_pick(r, m_ptr);
            m_busy = 1'b1;
            m_age  = 0;
         end
      end else if (d && m_age >= 1) begin
         t.idx = m_idx; t.len = m_age + 1; t.tmo = 1'b0;
         exp_q.push_back(t);
         m_ptr  = m_idx;
         m_busy = 1'b0;
      end else if (m_age == TIMEOUT - 1) begin
         t.idx = m_idx; t.len = TIMEOUT; t.tmo = 1'b1;
         exp_q.push_back(t);
         m_ptr  = m_idx;
         m_busy = 1'b0;
      end else begin
         m_age++;
      end
   endtask

   // Apply inputs for the next edge, wait for it, and advance the model.
   task automatic tick(input logic [7:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      if (!reset) model_edge(r, d);
      #1;
   endtask

   // Hold a request pattern; done is pulsed when the grant reaches age 'delay'.
   task automatic run(input logic [7:0] r, input int delay, input int cycles);
      for (int i = 0; i < cycles; i++) tick(r, m_busy && (m_age == delay));
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && m_busy; i++) tick(8'h00, m_age >= 1);
      tick(8'h00, 1'b0);
      tick(8'h00, 1'b0);
   endtask

   task automatic check_seq(input string nm, input int e[$]);
      chk({nm, "_count"}, 32'(obs_idx.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < obs_idx.size(); i++)
         chk(nm, 32'(obs_idx[i]), 32'(e[i]));
   endtask

   // ---------------- monitor ----------------
   bit   mon_prev = 1'b0;
   int   mon_idx  = 0;
   int   mon_len  = 0;
   int   mon_idle = 0;
   txn_t mon_t;

   always @(negedge clk) begin
      if (reset) begin
         mon_prev = 1'b0;
         mon_len  = 0;
         mon_idle = 0;
      end else begin
         chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
         chk("valid_vs_gnt", 32'(gnt_valid), 32'(|gnt));
         if (gnt_valid) begin
            chk("gnt_decode", 32'(gnt), 32'(8'd1 << gnt_idx));
            chk("timeout_in_grant", 32'(timeout), 32'd0);
            if (!mon_prev) begin
               chk("start_first", 32'(start), 32'd1);
               mon_idx = int'(gnt_idx);
               mon_len = 1;
               obs_idx.push_back(mon_idx);
               obs_gap.push_back(mon_idle);
            end else begin
               chk("start_later", 32'(start), 32'd0);
               chk("gnt_held", 32'(gnt_idx), 32'(mon_idx));
               mon_len++;
            end
         end else begin
            chk("idx_idle", 32'(gnt_idx), 32'd0);
            chk("start_idle", 32'(start), 32'd0);
            if (mon_prev) begin
               if (exp_q.size() == 0) begin
                  chk("release_unexpected", 32'd1, 32'd0);
               end else begin
                  mon_t = exp_q.pop_front();
                  chk("txn_idx", 32'(mon_idx), 32'(mon_t.idx));
                  chk("txn_len", 32'(mon_len), 32'(mon_t.len));
                  chk("txn_timeout", 32'(timeout), 32'(mon_t.tmo));
               end
               mon_idle = 1;
            end else begin
               chk("timeout_idle", 32'(timeout), 32'd0);
               mon_idle++;
            end
         end
         mon_prev = gnt_valid;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int seq[$];
      reset = 1'b1;
      req   = 8'h00;
      done  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_idx", 32'(gnt_idx), 32'd0);
      chk("rst_valid", 32'(gnt_valid), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      #1 reset = 1'b0;

      // basic alternation 2,0,2,0 with one idle cycle between grants
      obs_idx.delete(); obs_gap.delete();
      run(8'h05, 1, 12);
      drain();
      seq = {2, 0, 2, 0};
      check_seq("basic_order", seq);
      for (int i = 1; i < obs_gap.size() && i < 4; i++)
         chk("basic_gap", 32'(obs_gap[i]), 32'd1);

      // full downward rotation
      obs_idx.delete();
      run(8'hFF, 2, 36);
      drain();
      seq = {7, 6, 5, 4, 3, 2, 1, 0, 7};
      check_seq("rotation_order", seq);

      // watchdog: index 4 alone, no done
      obs_idx.delete(); obs_gap.delete();
      run(8'h10, -1, 67);
      drain();
      seq = {4, 4};
      check_seq("watchdog_order", seq);
      if (obs_gap.size() > 1) chk("watchdog_gap", 32'(obs_gap[1]), 32'd1);

      // ignored done events and request drop
      tick(8'h00, 1'b1);
      tick(8'h00, 1'b1);
      chk("done_in_idle", 32'(gnt_valid), 32'd0);
      tick(8'h08, 1'b0);
      tick(8'h08, 1'b1);
      chk("done_in_start", 32'(gnt_valid), 32'd1);
      tick(8'h00, 1'b0);
      tick(8'h00, 1'b0);
      chk("hold_after_drop", 32'(gnt), 32'h08);
      tick(8'h00, 1'b1);
      tick(8'h00, 1'b0);
      chk("release_on_done", 32'(gnt_valid), 32'd0);

      // asynchronous reset in the third grant cycle
      tick(8'h40, 1'b0);
      tick(8'h40, 1'b0);
      tick(8'h40, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_idx", 32'(gnt_idx), 32'd0);
      chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
      chk("mid_rst_start", 32'(start), 32'd0);
      chk("mid_rst_timeout", 32'(timeout), 32'd0);
      m_busy = 1'b0; m_ptr = 0; m_age = 0;
      @(posedge clk);
      #2 reset = 1'b0;
      obs_idx.delete();
      run(8'h81, 1, 3);
      drain();
      seq = {7};
      check_seq("after_reset", seq);

      // done coinciding with watchdog expiry, then pointer effect
      run(8'h20, TIMEOUT - 1, 66);
      drain();
      obs_idx.delete();
      run(8'h21, 1, 3);
      drain();
      seq = {0};
      check_seq("ptr_after_simul", seq);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] r;
         logic       d;
         r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         if (m_busy) d = (m_age == cur_delay);
         else        d = ($urandom_range(0, 3) == 0);
         tick(r, d);
         if (m_busy && m_age == 0) begin
            if ($urandom_range(0, 3) == 0) cur_delay = int'($urandom_range(0, 70));
            else                           cur_delay = int'($urandom_range(1, 6));
         end
      end
      drain();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL time_limit: got no finish, expected finish before limit");
      $fatal(1, "time limit reached");
   end

endmodule
